// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES byte/word/state helpers shared by the forward and inverse ciphers
package aes_pkg;

  localparam int BLK = 128;

  typedef enum logic [1:0] {IDLE, KEXP, INIT, ROUND} state_t;

  function automatic logic [7:0] xtimes(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtimes(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    s = gf_inv(x);
    return s ^ rotl8(s, 1) ^ rotl8(s, 2) ^ rotl8(s, 3) ^ rotl8(s, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Words keep byte 0 in the top bits, matching the column-major block layout
  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte k of a block sits at [BLK-1-8k -: 8]; k = 4*col + row
  function automatic logic [BLK-1:0] subbytes(input logic [BLK-1:0] s);
    logic [BLK-1:0] o;
    for (int k = 0; k < 16; k++) o[BLK-1-8*k -: 8] = sbox(s[BLK-1-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [BLK-1:0] inv_subbytes(input logic [BLK-1:0] s);
    logic [BLK-1:0] o;
    for (int k = 0; k < 16; k++) o[BLK-1-8*k -: 8] = inv_sbox(s[BLK-1-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [BLK-1:0] shiftrows(input logic [BLK-1:0] s);
    logic [BLK-1:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[BLK-1-8*(4*c+r) -: 8] = s[BLK-1-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [BLK-1:0] inv_shiftrows(input logic [BLK-1:0] s);
    logic [BLK-1:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[BLK-1-8*(4*c+r) -: 8] = s[BLK-1-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[31-8*k -: 8];
      m2[k] = xtimes(a[k]);
    end
    return {m2[0] ^ m2[1] ^ a[1] ^ a[2] ^ a[3],
            a[0] ^ m2[1] ^ m2[2] ^ a[2] ^ a[3],
            a[0] ^ a[1] ^ m2[2] ^ m2[3] ^ a[3],
            m2[0] ^ a[0] ^ a[1] ^ a[2] ^ m2[3]};
  endfunction

  // 0e/0b/0d/09 multiples built from a shared x2/x4/x8 chain per byte
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      a  = c[31-8*k -: 8];
      x2 = xtimes(a);
      x4 = xtimes(x2);
      x8 = xtimes(x4);
      m9[k] = x8 ^ a;
      mb[k] = x8 ^ x2 ^ a;
      md[k] = x8 ^ x4 ^ a;
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [BLK-1:0] mixcolumns(input logic [BLK-1:0] s);
    logic [BLK-1:0] o;
    for (int c = 0; c < 4; c++) o[BLK-1-32*c -: 32] = mix_col(s[BLK-1-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [BLK-1:0] inv_mixcolumns(input logic [BLK-1:0] s);
    logic [BLK-1:0] o;
    for (int c = 0; c < 4; c++) o[BLK-1-32*c -: 32] = inv_mix_col(s[BLK-1-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [BLK-1:0] addroundkey(input logic [BLK-1:0] s, input logic [BLK-1:0] rk);
    return s ^ rk;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLK-1:0] blk_i,
  input  logic [BLK-1:0] rk_i,
  input  logic           last_i,
  output logic [BLK-1:0] blk_o
);

  logic [BLK-1:0] keyed;

  // Final round skips InvMixColumns
  always_comb begin
    keyed = addroundkey(inv_subbytes(inv_shiftrows(blk_i)), rk_i);
    blk_o = last_i ? keyed : inv_mixcolumns(keyed);
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES decryptor, one round per clock, cached key schedule
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [BLK-1:0]   in,
  input  logic [32*Nk-1:0] key,
  output logic             ready,
  output logic [BLK-1:0]   out,
  output logic             valid_out
);

  localparam int NW = 4*Nr + 4;
  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0] FIRST_I = IW'(Nk);
  localparam logic [IW-1:0] LAST_I  = IW'(NW - 1);

  state_t           state_q;
  logic [BLK-1:0]   blk_q, out_q;
  logic [32*Nk-1:0] key_reg_q;
  logic             kv_q, valid_out_q;
  logic [31:0]      w_q [NW];
  logic [IW-1:0]    i_q;
  logic [2:0]       kmod_q;
  logic [3:0]       rci_q;
  logic [3:0]       r_q;

  logic [31:0]    w_prev, sw_in, sw_out, g, w_d;
  logic [3:0]     rk_sel;
  logic [IW-1:0]  rk_base;
  logic [BLK-1:0] rk, blk_d;

  // Next expanded word; the single subword serves both the Rcon and Nk>6 cases
  always_comb begin
    w_prev = w_q[i_q - IW'(1)];
    sw_in  = (kmod_q == 3'd0) ? rotword(w_prev) : w_prev;
    sw_out = subword(sw_in);
    if (kmod_q == 3'd0)                 g = sw_out ^ {rcon(rci_q), 24'h000000};
    else if (Nk > 6 && kmod_q == 3'd4)  g = sw_out;
    else                                g = w_prev;
    w_d = w_q[i_q - FIRST_I] ^ g;
  end

  // INIT whitens with rk(Nr); rounds use rk(r)
  always_comb begin
    rk_sel  = (state_q == INIT) ? 4'(Nr) : r_q;
    rk_base = IW'({rk_sel, 2'b00});
    rk      = {w_q[rk_base], w_q[rk_base + IW'(1)], w_q[rk_base + IW'(2)], w_q[rk_base + IW'(3)]};
  end

  aes_inv_round u_round (
    .blk_i  (blk_q),
    .rk_i   (rk),
    .last_i (r_q == 4'd0),
    .blk_o  (blk_d)
  );

  // Control FSM: accept, expand key on a miss, whiten, then Nr rounds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      out_q       <= '0;
      key_reg_q   <= '0;
      kv_q        <= 1'b0;
      valid_out_q <= 1'b0;
      i_q         <= '0;
      kmod_q      <= '0;
      rci_q       <= '0;
      r_q         <= '0;
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else begin
      valid_out_q <= 1'b0;
      case (state_q)
        IDLE: if (valid_in) begin
          blk_q     <= in;
          key_reg_q <= key;
          if (kv_q && key == key_reg_q) begin
            state_q <= INIT;
          end else begin
            kv_q <= 1'b0;
            for (int k = 0; k < Nk; k++) w_q[k] <= key[32*(Nk-1-k) +: 32];
            i_q     <= FIRST_I;
            kmod_q  <= 3'd0;
            rci_q   <= 4'd1;
            state_q <= KEXP;
          end
        end
        KEXP: begin
          w_q[i_q] <= w_d;
          i_q      <= i_q + IW'(1);
          kmod_q   <= (kmod_q == 3'(Nk - 1)) ? 3'd0 : kmod_q + 3'd1;
          if (kmod_q == 3'd0) rci_q <= rci_q + 4'd1;
          if (i_q == LAST_I) begin
            kv_q    <= 1'b1;
            state_q <= INIT;
          end
        end
        INIT: begin
          blk_q   <= addroundkey(blk_q, rk);
          r_q     <= 4'(Nr - 1);
          state_q <= ROUND;
        end
        ROUND: begin
          blk_q <= blk_d;
          if (r_q == 4'd0) begin
            out_q       <= blk_d;
            valid_out_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            r_q <= r_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = (state_q == IDLE) && !rst;
  assign out       = out_q;
  assign valid_out = valid_out_q;

endmodule
